turf_cmd_tx: RTL

TURF_CMD_TX -- requirements
Module: turf_cmd_tx

---
 rtl/turf_cmd_tx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/turf_cmd_tx.sv
// TURF serial command transmitter: 2-deep word queue feeding a framed bit serializer.
// Define CMD_TX_PARITY_EN to insert an even-parity bit ahead of the stop bit.
`timescale 1ns/1ps
module turf_cmd_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  cmd_type_i,
  input  logic [15:0] cmd_dat_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic        CMD,
  output logic        busy_o,
  output logic        sent_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_TYPE    = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_STOP    = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;

  localparam logic [7:0] TMR_LD = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] GAP_LD = 4'(GAP_BITS - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [18:0] shr_q, shr_d;
  logic        par_q, par_d;
  logic        cmd_q, cmd_d;
  logic        sent_q, sent_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [18:0] mem_q [2];
  logic [18:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;

  logic push, pop, tick, last, stop_end;

  assign cmd_ready_o = (cnt_q != 2'd2);
  assign busy_o      = (state_q != S_IDLE) || (cnt_q != 2'd0);
  assign CMD         = cmd_q;
  assign sent_o      = sent_q;
  assign frame_cnt_o = fcnt_q;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bcnt_d   = bcnt_q;
    shr_d    = shr_q;
    par_d    = par_q;
    cmd_d    = 1'b0;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    stop_end = 1'b0;
    push     = cmd_valid_i && cmd_ready_o;
    tick     = (tmr_q == 8'd0);
    last     = tick && (bcnt_q == 4'd0);

    if (state_q != S_IDLE) begin
      tmr_d = tick ? TMR_LD : tmr_q - 8'd1;
      if (tick && !last) bcnt_d = bcnt_q - 4'd1;
    end

    // CMD is driven from the current state, so it trails the FSM by one cycle
    unique case (state_q)
      S_IDLE: pop = (cnt_q != 2'd0);
      S_START: begin
        cmd_d = 1'b1;
        if (last) begin
          state_d = S_TYPE;
          bcnt_d  = 4'd2;
        end
      end
      S_TYPE: begin
        cmd_d = shr_q[18];
        if (tick) shr_d = shr_q << 1;
        if (last) begin
          state_d = S_PAYLOAD;
          bcnt_d  = 4'd15;
        end
      end
      S_PAYLOAD: begin
        cmd_d = shr_q[18];
        if (tick) shr_d = shr_q << 1;
        if (last) begin
`ifdef CMD_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
          bcnt_d = 4'd0;
        end
      end
      S_PARITY: begin
        cmd_d = par_q;
        if (last) begin
          state_d = S_STOP;
          bcnt_d  = 4'd0;
        end
      end
      S_STOP: begin
        if (last) begin
          stop_end = 1'b1;
          state_d  = S_GAP;
          bcnt_d   = GAP_LD;
        end
      end
      S_GAP: begin
        if (last) begin
          if (cnt_q != 2'd0) pop = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d  = S_START;
      bcnt_d   = 4'd0;
      tmr_d    = TMR_LD;
      shr_d    = mem_q[rd_ptr_q];
`ifdef CMD_TX_PARITY_EN
      par_d    = ^mem_q[rd_ptr_q];
`endif
      rd_ptr_d = ~rd_ptr_q;
    end

    if (push) begin
      mem_d[wr_ptr_q] = {cmd_type_i, cmd_dat_i};
      wr_ptr_d        = ~wr_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    sent_d = stop_end;
    fcnt_d = fcnt_q + {15'd0, stop_end};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      tmr_q    <= 8'd0;
      bcnt_q   <= 4'd0;
      shr_q    <= 19'd0;
      par_q    <= 1'b0;
      cmd_q    <= 1'b0;
      sent_q   <= 1'b0;
      fcnt_q   <= 16'd0;
      mem_q[0] <= 19'd0;
      mem_q[1] <= 19'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bcnt_q   <= bcnt_d;
      shr_q    <= shr_d;
      par_q    <= par_d;
      cmd_q    <= cmd_d;
      sent_q   <= sent_d;
      fcnt_q   <= fcnt_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
